btb_update_ctrl: RTL and testbench
==================================

# btb_update_ctrl

Sequencer sitting between the EX stage and the branch target buffer. Resolves each executed branch against its fetch-time prediction, raises a registered redirect on mispredict, and queues BTB write requests in a small FIFO drained one per cycle. Also runs a 256-cycle invalidation sweep on request (fence.i / context switch), stalling EX only when the queue overflows.

## Interface
- `DEPTH`, 4: update FIFO entries (power of two, ≥2)
- `IDX_W`, 8: BTB index width; sweep covers 2^IDX_W entries, index = pc[IDX_W+1:2]
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: reset; one clock, synchronous, active-high
- `ex_valid` in 1: EX holds a resolved control-transfer instruction
- `ex_taken` in 1: branch actually taken
- `ex_pc` in 32: branch PC
- `ex_target` in 32: actual target
- `ex_pred_hit` in 1: BTB hit recorded at fetch
- `ex_pred_target` in 32: predicted target recorded at fetch
- `flush_req` in 1: start invalidation sweep (pulse)
- `stall_ex` out 1: FIFO full; EX must hold its instruction
- `mispredict` out 1: registered redirect strobe
- `redirect_pc` out 32: correct fetch PC, valid with `mispredict`
- `br_update` out 1: BTB write strobe
- `pc_ex` out 32: BTB write PC
- `target_pc` out 32: BTB write target
- `btb_inv` out 1: invalidate strobe
- `inv_idx` out IDX_W: index to invalidate
- `sweep_busy` out 1: sweep in progress

## Operation
- Accept = `ex_valid & ~stall_ex`. With `stall_ex` high, all `ex_*` inputs are ignored.
- Mispredict on accept when either:
  - `ex_taken & (~ex_pred_hit | ex_pred_target != ex_target)`, with redirect = `ex_target`
  - `~ex_taken & ex_pred_hit`, with redirect = `ex_pc + 4` (32-bit wrap)
- Enqueue {ex_pc, ex_target} on accept when `ex_taken & ex_pc[1:0]==0 & (~ex_pred_hit | target mismatch)`. Not-taken branches never write.
- Drain: in IDLE with FIFO non-empty, pop head and drive `br_update`, `pc_ex`, `target_pc` (registered) for one cycle. One pop per cycle.
- Same-cycle push and pop: count is unchanged; the push goes behind the head.
- `stall_ex = (count == DEPTH)`. Drain may pop in the same cycle, but stall is still computed from the current count.
- FSM states:
  - IDLE: on `flush_req`, go to SWEEP and clear the FIFO. Any push in that same cycle is also discarded, because a stale target must not survive the flush.
  - SWEEP: `btb_inv=1`, `inv_idx` counts 0 to 2^IDX_W−1, one per cycle, `sweep_busy=1`, no drain. After the last index, return to IDLE. Pushes are accepted and held; drain resumes the cycle after return.
  - `flush_req` during SWEEP: restart at index 0 and clear the FIFO again.
- `br_update` and `btb_inv` are never high together.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE, `inv_idx=0`.
- `mispredict` / `redirect_pc`: cycle N+1 after accept in cycle N, high for exactly one cycle.
- Update latency: accept in N with empty FIFO in IDLE gives `br_update` in N+1. Each older queued entry adds one cycle.
- Sweep: `flush_req` in N gives `btb_inv` in N+1 through N+2^IDX_W, and IDLE in N+2^IDX_W+1.
- `rst` mid-sweep or with queued entries: everything is discarded and the next cycle shows reset values.
- `stall_ex` is combinational from the count register only, so it has no input-to-output path.

## Structure
- Shared package holds the FSM state encoding (IDLE, SWEEP), the FIFO entry struct {pc[31:0], target[31:0]}, and the `PC_INC=4` constant.
- Sub-module `btb_upd_fifo`: synchronous FIFO (DEPTH, 64-bit) with push, pop, clear, full, empty and count.
- Top level holds the resolve logic, FSM, sweep counter and output registers.

## Test plan
- Taken, `ex_pred_hit=0`, pc=0x100, target=0x200 gives `mispredict` with `redirect_pc=0x200` and `br_update` with pc_ex=0x100 / target_pc=0x200, both at N+1.
- Not-taken, `ex_pred_hit=1`, pc=0xFFFFFFFC gives `redirect_pc=0x00000000` and no `br_update`.
- Taken, hit, matching target gives no `mispredict` and no update. The same case with target mismatch 0x300 vs 0x304 gives an update with target_pc=0x304.
- `flush_req` in N gives `btb_inv` for 256 cycles with `inv_idx` 0 to 255. Five taken misses during the sweep give `stall_ex` after 4, the 5th held until drain, then `br_update` in order starting the cycle after the sweep ends.
- `flush_req` in the same cycle as a push with 2 entries queued: the FIFO is emptied and no `br_update` ever appears for those 3.
- `rst` at sweep index 100: the next cycle shows `btb_inv=0`, `sweep_busy=0` and `inv_idx=0`. Misaligned pc 0x102, taken, miss gives `mispredict` only.

Source files
------------

// File: rtl/btb_update_ctrl_pkg.sv
// Shared definitions for the BTB update sequencer: FSM encoding, queued
// update entry layout and the sequential-fetch increment.
package btb_update_ctrl_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } btb_entry_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO of pending BTB writes; head is visible combinationally
// so the top can register it on the pop cycle.
module btb_upd_fifo
    import btb_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  btb_entry_t    push_data_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output btb_entry_t    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    btb_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~clear_i;
    assign do_pop  = pop_i & ~empty_o & ~clear_i;

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Resolves EX branches against fetch predictions, emits redirects, queues and
// drains BTB writes, and runs the full-table invalidation sweep.
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_taken,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_hit,
    input  logic [31:0]      ex_pred_target,
    input  logic             flush_req,
    output logic             stall_ex,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             br_update,
    output logic [31:0]      pc_ex,
    output logic [31:0]      target_pc,
    output logic             btb_inv,
    output logic [IDX_W-1:0] inv_idx,
    output logic             sweep_busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mis_q, mis_d;
    logic [31:0]      redir_q, redir_d;
    logic             upd_q, upd_d;
    logic [31:0]      upd_pc_q, upd_pc_d;
    logic [31:0]      upd_tgt_q, upd_tgt_d;

    btb_entry_t    fifo_head, fifo_wdata;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0] fifo_count;

    logic accept, tgt_mismatch, wr_req, drain_ok, bypass;

    assign stall_ex     = fifo_full;
    assign accept       = ex_valid & ~stall_ex;
    assign tgt_mismatch = (ex_pred_target != ex_target);
    assign wr_req       = accept & ex_taken & (ex_pc[1:0] == 2'b00)
                        & (~ex_pred_hit | tgt_mismatch);

    // A write arriving at an empty idle queue skips the FIFO so it lands in N+1.
    assign drain_ok  = (state_q == ST_IDLE) & ~flush_req;
    assign bypass    = drain_ok & fifo_empty & wr_req;
    assign fifo_pop  = drain_ok & ~fifo_empty;
    assign fifo_push = wr_req & ~flush_req & ~bypass;
    assign fifo_wdata = '{pc: ex_pc, target: ex_target};

    btb_upd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_data_i(fifo_wdata),
        .pop_i      (fifo_pop),
        .clear_i    (flush_req),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_comb begin
        mis_d     = accept & ((ex_taken & (~ex_pred_hit | tgt_mismatch))
                            | (~ex_taken & ex_pred_hit));
        redir_d   = redir_q;
        if (mis_d) redir_d = ex_taken ? ex_target : ex_pc + PC_INC;

        upd_d     = bypass | fifo_pop;
        upd_pc_d  = upd_pc_q;
        upd_tgt_d = upd_tgt_q;
        if (fifo_pop) begin
            upd_pc_d  = fifo_head.pc;
            upd_tgt_d = fifo_head.target;
        end else if (bypass) begin
            upd_pc_d  = ex_pc;
            upd_tgt_d = ex_target;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (flush_req) begin
            state_d = ST_SWEEP;
            idx_d   = '0;
        end else if (state_q == ST_SWEEP) begin
            if (&idx_q) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            mis_q     <= 1'b0;
            redir_q   <= '0;
            upd_q     <= 1'b0;
            upd_pc_q  <= '0;
            upd_tgt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mis_q     <= mis_d;
            redir_q   <= redir_d;
            upd_q     <= upd_d;
            upd_pc_q  <= upd_pc_d;
            upd_tgt_q <= upd_tgt_d;
        end
    end

    assign mispredict  = mis_q;
    assign redirect_pc = redir_q;
    assign br_update   = upd_q;
    assign pc_ex       = upd_pc_q;
    assign target_pc   = upd_tgt_q;
    assign btb_inv     = (state_q == ST_SWEEP);
    assign sweep_busy  = (state_q == ST_SWEEP);
    assign inv_idx     = idx_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized and directed checks of btb_update_ctrl against a queue-based
// behavioural model of branch resolution, update drain and sweep.
module tb_btb_update_ctrl;
    localparam int DEPTH = 4;
    localparam int IDX_W = 8;
    localparam int NIDX  = 256;

    logic        clk = 1'b0;
    logic        rst, ex_valid, ex_taken, ex_pred_hit, flush_req;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        stall_ex, mispredict, br_update, btb_inv, sweep_busy;
    logic [31:0] redirect_pc, pc_ex, target_pc;
    logic [IDX_W-1:0] inv_idx;

    btb_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_taken(ex_taken),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_hit(ex_pred_hit),
        .ex_pred_target(ex_pred_target), .flush_req(flush_req),
        .stall_ex(stall_ex), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_update(br_update), .pc_ex(pc_ex), .target_pc(target_pc),
        .btb_inv(btb_inv), .inv_idx(inv_idx), .sweep_busy(sweep_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed { logic [31:0] pc; logic [31:0] tgt; } upd_t;
    upd_t mq[$];
    bit   m_sweep;
    int   m_idx;

    bit          exp_mis, exp_upd, exp_inv, exp_stall;
    logic [31:0] exp_redir, exp_pc, exp_tgt;
    int          exp_idx;

    task automatic idle_in();
        rst = 1'b0; flush_req = 1'b0; ex_valid = 1'b0; ex_taken = 1'b0;
        ex_pred_hit = 1'b0; ex_pc = '0; ex_target = '0; ex_pred_target = '0;
    endtask

    task automatic drive(input bit t, input bit h, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_taken = t; ex_pred_hit = h;
        ex_pc = pc; ex_target = tgt; ex_pred_target = ptgt;
    endtask

    // Advance one clock, evolving the model from the inputs currently driven.
    task automatic cycle();
        bit acc, wr, n_mis, n_upd, was_idle;
        logic [31:0] n_redir, n_pc, n_tgt;
        upd_t e;
        acc = ex_valid && (mq.size() != DEPTH) && !rst;
        n_mis = acc && ((ex_taken && (!ex_pred_hit || ex_pred_target != ex_target))
                        || (!ex_taken && ex_pred_hit));
        n_redir = ex_taken ? ex_target : ex_pc + 32'd4;
        wr = acc && ex_taken && (ex_pc[1:0] == 2'b00)
             && (!ex_pred_hit || ex_pred_target != ex_target);
        n_upd = 1'b0; n_pc = '0; n_tgt = '0;
        was_idle = !m_sweep;
        if (rst) begin
            mq.delete(); m_sweep = 0; m_idx = 0;
        end else if (flush_req) begin
            mq.delete(); m_sweep = 1; m_idx = 0;
        end else begin
            if (wr) mq.push_back('{pc: ex_pc, tgt: ex_target});
            if (was_idle && mq.size() > 0) begin
                e = mq.pop_front();
                n_upd = 1'b1; n_pc = e.pc; n_tgt = e.tgt;
            end
            if (m_sweep) begin
                if (m_idx == NIDX - 1) begin m_sweep = 0; m_idx = 0; end
                else m_idx++;
            end
        end
        @(posedge clk); #1;
        cyc++;
        exp_mis = n_mis; exp_redir = n_redir;
        exp_upd = n_upd; exp_pc = n_pc; exp_tgt = n_tgt;
        exp_inv = m_sweep; exp_idx = m_idx; exp_stall = (mq.size() == DEPTH);
    endtask

    task automatic test_reset();
        idle_in(); rst = 1'b1;
        cycle(); cycle();
        idle_in();
        total++; if ({mispredict, br_update, btb_inv, sweep_busy, stall_ex} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {mispredict, br_update, btb_inv, sweep_busy, stall_ex});
        end
        total++; if ({redirect_pc, pc_ex, target_pc} !== 96'h0) begin
            bad++; $display("FAIL reset_data redir=%h pc=%h tgt=%h exp=0", redirect_pc, pc_ex, target_pc);
        end
        total++; if (inv_idx !== 8'd0) begin
            bad++; $display("FAIL reset_idx got=%0d exp=0", inv_idx);
        end
        $display("reset: mis=%b upd=%b inv=%b idx=%0d", mispredict, br_update, btb_inv, inv_idx);
    endtask

    task automatic test_resolve();
        logic [31:0] vec [5][3];
        bit tk [5];
        bit ht [5];
        logic [31:0] want_redir [5];
        vec[0] = '{32'h100, 32'h200, 32'h0};      tk[0] = 1; ht[0] = 0; want_redir[0] = 32'h200;
        vec[1] = '{32'hFFFFFFFC, 32'h40, 32'h40}; tk[1] = 0; ht[1] = 1; want_redir[1] = 32'h0;
        vec[2] = '{32'h200, 32'h300, 32'h300};    tk[2] = 1; ht[2] = 1; want_redir[2] = 32'h0;
        vec[3] = '{32'h200, 32'h304, 32'h300};    tk[3] = 1; ht[3] = 1; want_redir[3] = 32'h304;
        vec[4] = '{32'h102, 32'h200, 32'h0};      tk[4] = 1; ht[4] = 0; want_redir[4] = 32'h200;
        for (int i = 0; i < 5; i++) begin
            drive(tk[i], ht[i], vec[i][0], vec[i][1], vec[i][2]);
            cycle();
            idle_in();
            total++; if (mispredict !== exp_mis || br_update !== exp_upd) begin
                bad++; $display("FAIL resolve%0d_strobes mis=%b upd=%b exp mis=%b upd=%b", i, mispredict, br_update, exp_mis, exp_upd);
            end
            if (exp_mis) begin
                total++; if (redirect_pc !== want_redir[i]) begin
                    bad++; $display("FAIL resolve%0d_redirect got=%h exp=%h", i, redirect_pc, want_redir[i]);
                end
            end
            if (exp_upd) begin
                total++; if (pc_ex !== vec[i][0] || target_pc !== vec[i][1]) begin
                    bad++; $display("FAIL resolve%0d_update pc=%h tgt=%h exp pc=%h tgt=%h", i, pc_ex, target_pc, vec[i][0], vec[i][1]);
                end
            end
            $display("resolve%0d: pc=%h mis=%b redir=%h upd=%b tgt=%h", i, vec[i][0], mispredict, redirect_pc, br_update, target_pc);
            cycle();
        end
    endtask

    task automatic test_sweep_stall();
        int k = 0, n_upd = 0;
        bit saw_stall = 0, acc;
        idle_in(); flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        for (int c = 0; c < NIDX + 20; c++) begin
            if (k < 5) drive(1, 0, 32'h1000 + 32'(k) * 16, 32'h8000 + 32'(k) * 4, 32'h0);
            else idle_in();
            acc = (k < 5) && (mq.size() != DEPTH);
            cycle();
            if (acc) k++;
            if (stall_ex) saw_stall = 1;
            if (br_update) n_upd++;
            total++; if (btb_inv !== exp_inv || sweep_busy !== exp_inv || stall_ex !== exp_stall) begin
                bad++; $display("FAIL sweep_flags cyc=%0d inv=%b busy=%b stall=%b exp inv=%b stall=%b", cyc, btb_inv, sweep_busy, stall_ex, exp_inv, exp_stall);
            end
            total++; if (int'(inv_idx) !== exp_idx || br_update !== exp_upd) begin
                bad++; $display("FAIL sweep_idx cyc=%0d idx=%0d upd=%b exp idx=%0d upd=%b", cyc, inv_idx, br_update, exp_idx, exp_upd);
            end
            if (exp_upd) begin
                total++; if (pc_ex !== exp_pc || target_pc !== exp_tgt) begin
                    bad++; $display("FAIL sweep_drain cyc=%0d pc=%h tgt=%h exp pc=%h tgt=%h", cyc, pc_ex, target_pc, exp_pc, exp_tgt);
                end
                $display("sweep drain: pc=%h tgt=%h", pc_ex, target_pc);
            end
        end
        total++; if (n_upd !== 5 || saw_stall !== 1'b1) begin
            bad++; $display("FAIL sweep_summary updates=%0d stall_seen=%b exp 5 and 1", n_upd, saw_stall);
        end
        $display("sweep: updates=%0d stall_seen=%b", n_upd, saw_stall);
    endtask

    task automatic test_flush_push();
        int n_upd = 0;
        idle_in(); flush_req = 1'b1;
        cycle();
        idle_in(); drive(1, 0, 32'h2000, 32'h2100, 32'h0); cycle();
        idle_in(); drive(1, 0, 32'h2004, 32'h2200, 32'h0); cycle();
        drive(1, 0, 32'h2008, 32'h2300, 32'h0); flush_req = 1'b1;
        cycle();
        idle_in();
        for (int c = 0; c < NIDX + 10; c++) begin
            cycle();
            if (br_update) n_upd++;
            total++; if (br_update !== exp_upd || btb_inv !== exp_inv || int'(inv_idx) !== exp_idx) begin
                bad++; $display("FAIL flush_push cyc=%0d upd=%b inv=%b idx=%0d exp upd=%b inv=%b idx=%0d", cyc, br_update, btb_inv, inv_idx, exp_upd, exp_inv, exp_idx);
            end
        end
        total++; if (n_upd !== 0) begin
            bad++; $display("FAIL flush_push_count updates=%0d exp=0", n_upd);
        end
        $display("flush_push: updates after flush=%0d", n_upd);
    endtask

    task automatic test_rst_mid_sweep();
        int guard = 0;
        idle_in(); flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        drive(1, 0, 32'h3000, 32'h3100, 32'h0); cycle(); idle_in();
        while (exp_idx != 100 && guard < 400) begin cycle(); guard++; end
        total++; if (int'(inv_idx) !== 100) begin
            bad++; $display("FAIL rst_sweep_reach idx=%0d exp=100", inv_idx);
        end
        rst = 1'b1; cycle(); rst = 1'b0;
        total++; if (btb_inv !== 1'b0 || sweep_busy !== 1'b0 || inv_idx !== 8'd0) begin
            bad++; $display("FAIL rst_sweep inv=%b busy=%b idx=%0d exp 0 0 0", btb_inv, sweep_busy, inv_idx);
        end
        cycle();
        total++; if (br_update !== 1'b0 || stall_ex !== 1'b0) begin
            bad++; $display("FAIL rst_sweep_queue upd=%b stall=%b exp 0 0", br_update, stall_ex);
        end
        $display("rst mid-sweep: inv=%b busy=%b idx=%0d", btb_inv, sweep_busy, inv_idx);
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int c = 0; c < 3000; c++) begin
            idle_in();
            rst = ($urandom_range(0, 299) == 0);
            flush_req = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 9) < 6) begin
                tgt = 32'h4000 + 32'($urandom_range(0, 7)) * 4;
                drive($urandom_range(0, 1), $urandom_range(0, 1),
                      ($urandom_range(0, 4) == 0) ? $urandom : {$urandom_range(0, 255) , 2'b00},
                      tgt, $urandom_range(0, 1) ? tgt : tgt + 32'd4);
            end
            cycle();
            total++; if (mispredict !== exp_mis || br_update !== exp_upd || stall_ex !== exp_stall) begin
                bad++; $display("FAIL rand_strobes cyc=%0d mis=%b upd=%b stall=%b exp %b %b %b", cyc, mispredict, br_update, stall_ex, exp_mis, exp_upd, exp_stall);
            end
            total++; if (btb_inv !== exp_inv || sweep_busy !== exp_inv || int'(inv_idx) !== exp_idx) begin
                bad++; $display("FAIL rand_sweep cyc=%0d inv=%b busy=%b idx=%0d exp inv=%b idx=%0d", cyc, btb_inv, sweep_busy, inv_idx, exp_inv, exp_idx);
            end
            if (exp_mis) begin
                total++; if (redirect_pc !== exp_redir) begin
                    bad++; $display("FAIL rand_redirect cyc=%0d got=%h exp=%h", cyc, redirect_pc, exp_redir);
                end
            end
            if (exp_upd) begin
                total++; if (pc_ex !== exp_pc || target_pc !== exp_tgt) begin
                    bad++; $display("FAIL rand_update cyc=%0d pc=%h tgt=%h exp pc=%h tgt=%h", cyc, pc_ex, target_pc, exp_pc, exp_tgt);
                end
            end
            if (exp_mis || exp_upd)
                $display("rand cyc=%0d mis=%b redir=%h upd=%b pc=%h tgt=%h", cyc, mispredict, redirect_pc, br_update, pc_ex, target_pc);
        end
    endtask

    initial begin
        idle_in();
        mq.delete(); m_sweep = 0; m_idx = 0;
        test_reset();
        test_resolve();
        test_sweep_stall();
        test_flush_push();
        test_rst_mid_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
